// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the IF/DE/MW pipeline control logic.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN,
        MEM_WAIT,
        REDIRECT
    } state_t;

    localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer: MW memory holds, DE branch bubbles,
// MW->DE forwarding selects and stall/flush performance counters.
module hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int FLUSH_CYC   = 1,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rs1_DE,
    input  logic [4:0]       rs2_DE,
    input  logic [4:0]       rd_MW,
    input  logic             reg_wr_MW,
    input  logic             dmem_req_MW,
    input  logic             dmem_ready,
    input  logic             br_taken,
    output logic             stall_IF,
    output logic             Control_stall,
    output logic             flush_DE,
    output logic             mem_abort,
    output logic             fwd_a,
    output logic             fwd_b,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_cycles
);

    localparam int WW = $clog2(MEM_TIMEOUT);
    localparam logic [WW-1:0] WAIT_LAST  = WW'(MEM_TIMEOUT - 1);
    localparam logic [2:0]    FLUSH_LAST = 3'(FLUSH_CYC - 1);

    state_t        state;
    state_t        state_nxt;
    logic [WW-1:0] wait_cnt;
    logic [WW-1:0] wait_nxt;
    logic [2:0]    flush_cnt;
    logic [2:0]    flush_nxt;
    logic          abort_raw;
    logic          mem_hold;
    logic          flush_raw;
    logic          fwd_a_raw;
    logic          fwd_b_raw;

    assign abort_raw = (state == MEM_WAIT)
                     && (wait_cnt == WAIT_LAST)
                     && !dmem_ready;

    assign mem_hold = dmem_req_MW && !dmem_ready && !abort_raw;

    assign fwd_a_raw = reg_wr_MW
                     && (rd_MW != REG_X0)
                     && (rd_MW == rs1_DE);
    assign fwd_b_raw = reg_wr_MW
                     && (rd_MW != REG_X0)
                     && (rd_MW == rs2_DE);

    // Outputs are forced low while reset is held, not just after the edge.
    assign stall_IF      = rst && mem_hold;
    assign Control_stall = rst && mem_hold;
    assign flush_DE      = rst && flush_raw;
    assign mem_abort     = rst && abort_raw;
    assign fwd_a         = rst && fwd_a_raw;
    assign fwd_b         = rst && fwd_b_raw;

    always_comb begin
        state_nxt = state;
        wait_nxt  = wait_cnt;
        flush_nxt = flush_cnt;
        flush_raw = 1'b0;
        unique case (state)
            RUN, MEM_WAIT: begin
                if (mem_hold) begin
                    state_nxt = MEM_WAIT;
                    if (state == RUN) begin
                        wait_nxt = WW'(1);
                    end else begin
                        wait_nxt = wait_cnt + WW'(1);
                    end
                end else begin
                    // Leaving a wait frees DE, so a pending branch acts now.
                    state_nxt = RUN;
                    wait_nxt  = '0;
                    if (br_taken) begin
                        flush_raw = 1'b1;
                        if (FLUSH_CYC > 1) begin
                            state_nxt = REDIRECT;
                            flush_nxt = 3'd1;
                        end
                    end
                end
            end
            REDIRECT: begin
                flush_raw = 1'b1;
                if (!mem_hold) begin
                    if (flush_cnt == FLUSH_LAST) begin
                        state_nxt = RUN;
                        flush_nxt = 3'd0;
                    end else begin
                        flush_nxt = flush_cnt + 3'd1;
                    end
                end
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= RUN;
            wait_cnt  <= '0;
            flush_cnt <= 3'd0;
            mem_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            wait_cnt  <= wait_nxt;
            flush_cnt <= flush_nxt;
            if (abort_raw) begin
                mem_err <= 1'b1;
            end
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (Control_stall),
        .q   (stall_cycles)
    );

    sat_counter #(
        .W (CNT_W)
    ) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .inc (flush_DE),
        .q   (flush_cycles)
    );

endmodule
